// File: rtl/ladder_swap_seq.sv
// rtl/ladder_swap_seq.sv - X25519 Montgomery ladder conditional-swap sequencer
//
// Latches (and optionally clamps) the scalar, walks bit indices TOP down to 0,
// and for each bit drives one swap/swap_en transaction into the swap stage,
// waits for its swap_vld, then launches one ladder step and waits for
// step_done. After bit 0 a final un-swap is issued, then done pulses.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   start      1-cycle request to begin (ignored while busy)
//   scalar     scalar k, sampled when start is accepted
//   swap_vld   valid pulse from the swap stage
//   step_done  1-cycle pulse from the ladder-step datapath
//   swap       swap bit to the swap stage (stable until the next swap_en)
//   swap_en    1-cycle enable to the swap stage
//   step_start 1-cycle ladder-step launch
//   bitidx     current bit index
//   final_flag high while the final un-swap is in flight ("final" is a
//              reserved word, so the port carries a suffix)
//   busy       high from start acceptance until done
//   done       1-cycle completion pulse
//   proto_err  sticky flag for handshakes arriving in the wrong state

module ladder_swap_seq #(
    parameter int WID   = 256,
    parameter int TOP   = 254,
    parameter bit CLAMP = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [WID-1:0] scalar,
    input  logic           swap_vld,
    input  logic           step_done,
    output logic           swap,
    output logic           swap_en,
    output logic           step_start,
    output logic [7:0]     bitidx,
    output logic           final_flag,
    output logic           busy,
    output logic           done,
    output logic           proto_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAITSW, S_STEP, S_WAITST, S_FIN, S_FWAIT, S_DONE
    } state_t;

    state_t         state, state_n;
    logic [WID-1:0] kreg, kreg_n;
    logic [WID-1:0] scalar_c;
    logic           swapacc, swapacc_n;
    logic           kbit;
    logic           swap_n, swap_en_n, step_start_n, final_n;
    logic           busy_n, done_n, perr_n;
    logic [7:0]     bitidx_n;

    // X25519 clamping: clear the cofactor bits, force the top bit pattern.
    always_comb begin
        scalar_c = scalar;
        if (CLAMP) begin
            scalar_c[2:0]     = 3'b000;
            scalar_c[WID-1]   = 1'b0;
            scalar_c[WID-2]   = 1'b1;
        end
    end

    assign kbit = kreg[bitidx];

    // swap, swap_en, step_start and done are all registered: the new swap
    // value and its enable leave the block on the same cycle (the first
    // cycle of WAITSW/FWAIT), so the swap stage never samples a stale bit.
    always_comb begin
        state_n      = state;
        kreg_n       = kreg;
        swapacc_n    = swapacc;
        swap_n       = swap;
        swap_en_n    = 1'b0;
        step_start_n = 1'b0;
        bitidx_n     = bitidx;
        final_n      = final_flag;
        busy_n       = busy;
        done_n       = 1'b0;
        perr_n       = proto_err;

        if (swap_vld && !(state == S_WAITSW || state == S_FWAIT)) begin
            perr_n = 1'b1;
        end
        if (step_done && state != S_WAITST) begin
            perr_n = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    kreg_n    = scalar_c;
                    swapacc_n = 1'b0;
                    bitidx_n  = 8'(TOP);
                    busy_n    = 1'b1;
                    state_n   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Swap only when this bit differs from the previous one.
                swap_n    = swapacc ^ kbit;
                swapacc_n = kbit;
                swap_en_n = 1'b1;
                state_n   = S_WAITSW;
            end
            S_WAITSW: begin
                if (swap_vld) begin
                    state_n = S_STEP;
                end
            end
            S_STEP: begin
                step_start_n = 1'b1;
                state_n      = S_WAITST;
            end
            S_WAITST: begin
                if (step_done) begin
                    if (bitidx == 8'd0) begin
                        state_n = S_FIN;
                    end else begin
                        bitidx_n = bitidx - 8'd1;
                        state_n  = S_ISSUE;
                    end
                end
            end
            S_FIN: begin
                // Undo whatever swap is still pending from bit 0.
                swap_n    = swapacc;
                final_n   = 1'b1;
                swap_en_n = 1'b1;
                state_n   = S_FWAIT;
            end
            S_FWAIT: begin
                if (swap_vld) begin
                    final_n = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            kreg       <= '0;
            swapacc    <= 1'b0;
            swap       <= 1'b0;
            swap_en    <= 1'b0;
            step_start <= 1'b0;
            bitidx     <= 8'd0;
            final_flag <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            state      <= state_n;
            kreg       <= kreg_n;
            swapacc    <= swapacc_n;
            swap       <= swap_n;
            swap_en    <= swap_en_n;
            step_start <= step_start_n;
            bitidx     <= bitidx_n;
            final_flag <= final_n;
            busy       <= busy_n;
            done       <= done_n;
            proto_err  <= perr_n;
        end
    end

endmodule

// File: tb/tb_ladder_swap_seq.sv
// tb/tb_ladder_swap_seq.sv - self-checking bench for ladder_swap_seq

module tb_ladder_swap_seq;

    typedef struct {
        int   idx;
        logic sw;
        logic fin;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start [2];
    logic [255:0] scalar [2];
    logic         swap_vld [2];
    logic         step_done [2];

    logic         d_swap [2];
    logic         d_swap_en [2];
    logic         d_step_start [2];
    logic [7:0]   d_bitidx [2];
    logic         d_final [2];
    logic         d_busy [2];
    logic         d_done [2];
    logic         d_perr [2];

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    ev_t exp_q [2][$];
    int  n_en [2]   = '{0, 0};
    int  n_st [2]   = '{0, 0};
    int  n_done [2] = '{0, 0};
    int  sw_cnt [2] = '{0, 0};
    int  st_cnt [2] = '{0, 0};
    bit  outstanding [2] = '{0, 0};
    int  inj_vld_req [2]  = '{0, 0};
    int  inj_vld_ack [2]  = '{0, 0};
    int  inj_done_req [2] = '{0, 0};
    int  inj_done_ack [2] = '{0, 0};
    bit  exp_perr [2] = '{0, 0};
    bit  lat_rand = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ladder_swap_seq #(.WID(256), .TOP(254), .CLAMP(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .scalar(scalar[0]),
        .swap_vld(swap_vld[0]), .step_done(step_done[0]),
        .swap(d_swap[0]), .swap_en(d_swap_en[0]), .step_start(d_step_start[0]),
        .bitidx(d_bitidx[0]), .final_flag(d_final[0]), .busy(d_busy[0]),
        .done(d_done[0]), .proto_err(d_perr[0])
    );

    ladder_swap_seq #(.WID(256), .TOP(255), .CLAMP(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .scalar(scalar[1]),
        .swap_vld(swap_vld[1]), .step_done(step_done[1]),
        .swap(d_swap[1]), .swap_en(d_swap_en[1]), .step_start(d_step_start[1]),
        .bitidx(d_bitidx[1]), .final_flag(d_final[1]), .busy(d_busy[1]),
        .done(d_done[1]), .proto_err(d_perr[1])
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic int top_of(input int j);
        return (j == 0) ? 254 : 255;
    endfunction

    // Closed form: the swap at bit i is k[i] xor k[i+1] (nothing above TOP),
    // and the final un-swap is k[0].
    function automatic void build(input int j, input logic [255:0] s);
        logic [255:0] k;
        logic         prev;
        k = s;
        if (j == 0) begin
            k[2:0] = 3'b000;
            k[255] = 1'b0;
            k[254] = 1'b1;
        end
        exp_q[j].delete();
        for (int i = top_of(j); i >= 0; i--) begin
            prev = (i == top_of(j)) ? 1'b0 : k[i+1];
            exp_q[j].push_back('{i, k[i] ^ prev, 1'b0});
        end
        exp_q[j].push_back('{0, k[0], 1'b1});
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // Swap-stage / step-datapath responders plus the per-cycle output checker.
    always @(negedge clk) begin
        ev_t e;
        for (int j = 0; j < 2; j++) begin
            if (rst) begin
                sw_cnt[j] = 0;
                st_cnt[j] = 0;
                outstanding[j] = 1'b0;
                swap_vld[j] = 1'b0;
                step_done[j] = 1'b0;
                inj_vld_ack[j] = inj_vld_req[j];
                inj_done_ack[j] = inj_done_req[j];
            end else begin
                if (d_swap_en[j]) begin
                    n_en[j]++;
                    chk("no_reissue_before_vld", outstanding[j], 0);
                    outstanding[j] = 1'b1;
                    if (exp_q[j].size() == 0) begin
                        chk("unexpected_swap_en", 1, 0);
                    end else begin
                        e = exp_q[j].pop_front();
                        chk($sformatf("swap_u%0d_idx%0d", j, e.idx), d_swap[j], e.sw);
                        chk("bitidx", d_bitidx[j], e.idx);
                        chk("final_flag", d_final[j], e.fin);
                    end
                end
                if (d_step_start[j]) n_st[j]++;
                if (d_done[j]) begin
                    n_done[j]++;
                    chk("done_all_swaps_issued", exp_q[j].size(), 0);
                    chk("busy_during_done", d_busy[j], 1);
                end
                swap_vld[j] = 1'b0;
                step_done[j] = 1'b0;
                if (sw_cnt[j] > 0) begin
                    sw_cnt[j]--;
                    if (sw_cnt[j] == 0) begin
                        swap_vld[j] = 1'b1;
                        outstanding[j] = 1'b0;
                    end
                end
                if (d_swap_en[j]) sw_cnt[j] = lat_rand ? int'($urandom_range(1, 4)) : 3;
                if (st_cnt[j] > 0) begin
                    st_cnt[j]--;
                    if (st_cnt[j] == 0) step_done[j] = 1'b1;
                end
                if (d_step_start[j]) st_cnt[j] = lat_rand ? int'($urandom_range(1, 6)) : 5;
                if (inj_vld_req[j] != inj_vld_ack[j]) begin
                    swap_vld[j] = 1'b1;
                    inj_vld_ack[j] = inj_vld_req[j];
                end
                if (inj_done_req[j] != inj_done_ack[j]) begin
                    step_done[j] = 1'b1;
                    inj_done_ack[j] = inj_done_req[j];
                end
            end
        end
    end

    task automatic chk_zero(input int j);
        chk("rst_swap", d_swap[j], 0);
        chk("rst_swap_en", d_swap_en[j], 0);
        chk("rst_step_start", d_step_start[j], 0);
        chk("rst_bitidx", d_bitidx[j], 0);
        chk("rst_final", d_final[j], 0);
        chk("rst_busy", d_busy[j], 0);
        chk("rst_done", d_done[j], 0);
        chk("rst_proto_err", d_perr[j], 0);
    endtask

    // Called at posedge+1. Optional: restart_idx drives a second start while
    // busy, rst_idx resets in WAITST at that index, inj_idx injects swap_vld
    // in WAITST at that index.
    task automatic run(input int j, input logic [255:0] s, input int restart_idx,
                       input int rst_idx, input int inj_idx, output int cycles);
        int t0, e0, s0, d0;
        bit got, fired;
        build(j, s);
        e0 = n_en[j];
        s0 = n_st[j];
        d0 = n_done[j];
        got = 0;
        fired = 0;
        cycles = -1;
        start[j] = 1'b1;
        scalar[j] = s;
        t0 = cyc;
        for (int c = 0; c < 20000 && !got; c++) begin
            @(posedge clk); #1;
            start[j] = 1'b0;
            if (c == 0) scalar[j] = ~s;
            if (d_done[j]) begin
                got = 1;
                cycles = cyc - t0;
            end else if (rst_idx >= 0 && d_step_start[j] && d_bitidx[j] == 8'(rst_idx)) begin
                rst = 1'b1;
                #1;
                chk_zero(j);
                exp_q[0].delete();
                exp_q[1].delete();
                exp_perr[0] = 1'b0;
                exp_perr[1] = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end else begin
                if (restart_idx >= 0 && !fired && d_bitidx[j] == 8'(restart_idx)) begin
                    start[j] = 1'b1;
                    scalar[j] = rnd256();
                    fired = 1;
                end
                if (inj_idx >= 0 && !fired && d_step_start[j] && d_bitidx[j] == 8'(inj_idx)) begin
                    inj_vld_req[j]++;
                    fired = 1;
                end
            end
        end
        if (!got) begin
            chk("done_timeout", 0, 1);
            return;
        end
        @(posedge clk); #1;
        chk("busy_after_done", d_busy[j], 0);
        chk("done_one_cycle", d_done[j], 0);
        chk("swap_en_count", n_en[j] - e0, top_of(j) + 2);
        chk("step_start_count", n_st[j] - s0, top_of(j) + 1);
        chk("done_count", n_done[j] - d0, 1);
        chk("proto_err", d_perr[j], exp_perr[j]);
    endtask

    initial begin
        int ta, tb, t;
        rst = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        scalar[0] = '0;
        scalar[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero(0);
        chk_zero(1);
        rst = 1'b0;
        @(posedge clk); #1;

        // k = 0 clamped -> 2^254
        build(0, '0);
        chk("pin_zero_idx254", exp_q[0][0].sw, 1);
        chk("pin_zero_idx253", exp_q[0][1].sw, 1);
        chk("pin_zero_idx252", exp_q[0][2].sw, 0);
        chk("pin_zero_final", exp_q[0][255].sw, 0);
        run(0, '0, -1, -1, -1, t);
        chk("latency_fixed", t, 3066);

        // all ones clamped
        build(0, '1);
        chk("pin_ones_idx254", exp_q[0][0].sw, 1);
        chk("pin_ones_idx253", exp_q[0][1].sw, 0);
        chk("pin_ones_idx2", exp_q[0][252].sw, 1);
        chk("pin_ones_idx1", exp_q[0][253].sw, 0);
        chk("pin_ones_final", exp_q[0][255].sw, 0);
        run(0, '1, -1, -1, -1, t);

        // all ones, no clamp, TOP=255
        build(1, '1);
        chk("pin_noclamp_idx255", exp_q[1][0].sw, 1);
        chk("pin_noclamp_idx254", exp_q[1][1].sw, 0);
        chk("pin_noclamp_final", exp_q[1][256].sw, 1);
        chk("pin_noclamp_len", exp_q[1].size(), 257);
        run(1, '1, -1, -1, -1, t);

        // second start while busy is ignored
        begin
            logic [255:0] s;
            s = rnd256();
            run(0, s, -1, -1, -1, ta);
            run(0, s, 100, -1, -1, tb);
            chk("restart_ignored_timing", tb, ta);
            chk("restart_ref_timing", ta, 3066);
        end

        // reset mid-run, then a clean full run
        run(0, rnd256(), -1, 37, -1, t);
        run(0, rnd256(), -1, -1, -1, t);

        // protocol errors: step_done in IDLE, swap_vld in WAITST
        inj_done_req[0]++;
        repeat (3) @(posedge clk);
        #1;
        chk("proto_err_idle_step_done", d_perr[0], 1);
        exp_perr[0] = 1'b1;
        run(0, rnd256(), -1, -1, 200, t);
        chk("proto_err_other_unit", d_perr[1], 0);

        // random latencies and scalars
        lat_rand = 1'b1;
        for (int r = 0; r < 3; r++) run(0, rnd256(), -1, -1, -1, t);
        run(1, rnd256(), -1, -1, -1, t);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
